cmp_share_sched: RTL
====================

# cmp_share_sched

Round-robin scheduler that shares one registered 4-bit magnitude comparator among N requesters. Each requester presents an operand pair and holds a request until it receives an acknowledge. The scheduler then performs a fixed 4-cycle sequence: grant, operand capture, evaluate, respond. It sits between the requesting control blocks and the comparator datapath, so a single comparator serves every client and no client can starve another.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 4, operand width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request, level, held until ack
- a_flat  input  N_REQ*W  operand A of requester i at bits [i*W +: W]
- b_flat  input  N_REQ*W  operand B of requester i at bits [i*W +: W]
- ack  output  N_REQ  one-hot, one-cycle pulse in DONE to the served requester
- res_valid  output  1  result qualifier, high only in DONE
- res_id  output  3  index of the served requester
- res_gt  output  1  A > B (unsigned)
- res_eq  output  1  A == B
- res_lt  output  1  A < B
- busy  output  1  high whenever the state is not IDLE
- cmp_count  output  16  count of completed compares, saturates at 0xFFFF

## Operation
- States: IDLE -> CAPTURE -> EVAL -> DONE -> IDLE. No other transitions exist. The FSM never holds in CAPTURE, EVAL or DONE.
- IDLE with req == 0: stay in IDLE.
- IDLE with any req bit set: choose the winner, register it in res_id, go to CAPTURE.
- Winner selection: the first set bit of req, searching from ptr upward and wrapping modulo N_REQ.
- CAPTURE: latch a_flat and b_flat slices for res_id into opA and opB. Later operand changes do not affect this transaction.
- EVAL: unsigned compare of opA and opB. Register gt, eq and lt. Exactly one of the three is 1.
- DONE:
  - res_valid = 1 and ack[res_id] = 1.
  - ptr <= (res_id + 1) mod N_REQ.
  - cmp_count increments unless it is already 0xFFFF.
  - Next state is IDLE.
- res_gt, res_eq, res_lt and res_id hold their values until the next EVAL or CAPTURE overwrites them.
- Requester protocol: on seeing ack high, a requester drops req at the same clock edge. If req is still high in the following IDLE cycle, that is a new request.
- If req drops during CAPTURE, EVAL or DONE, the transaction still completes and ack still pulses. The requester ignores the pulse.
- Reset values, all outputs and state:
  - state = IDLE, ptr = 0
  - ack = 0, res_valid = 0, busy = 0
  - res_id = 0, res_gt = 0, res_eq = 0, res_lt = 0
  - cmp_count = 0
  - opA = 0, opB = 0
- Reset asserted mid-transaction aborts it: no ack is issued, and after release the FSM starts in IDLE.

## Timing
- Let T0 be the IDLE cycle in which a request is seen.
  - T0+1: CAPTURE
  - T0+2: EVAL
  - T0+3: DONE, with ack and res_valid high
  - T0+4: IDLE, which can accept the next request
- Latency from request to ack is 3 cycles. Sustained throughput is one compare per 4 cycles.
- ack and res_valid are registered outputs, decoded from the state register and res_id with no combinational path from req.
- busy is high in T0+1..T0+3.
- Worst-case wait for a continuously requesting client is (N_REQ-1)*4 cycles plus its own 4.
- Release of rst_n is assumed synchronous to clk externally. The first legal IDLE evaluation is the first edge after release.

## Test plan
- Single request: req=0001, A0=9, B0=3.
  - Expected: ack=0001 and res_valid at T0+3, res_gt=1, res_id=0, cmp_count=1, busy high for 3 cycles.
- Equal and less cases: requester 2 with A=5, B=5, then A=2, B=14.
  - Expected: res_eq=1 on the first, res_lt=1 on the second, res_id=2 both times.
- Round-robin fairness: req=1111 held, re-raised after each ack, all pairs distinct.
  - Expected: acks in order 0,1,2,3,0, each exactly 4 cycles apart.
  - Repeat starting with ptr=2 and req=0101: expected order 2,0.
- Operand change after capture: A1=15, B1=0, then change A1 to 0 at T0+2.
  - Expected: res_gt=1, since the captured operands are used.
- Reset mid-operation: assert rst_n=0 during EVAL.
  - Expected: no ack, all outputs at their reset values.
  - After release with req still high: a normal transaction starting at ptr=0.
- Counter saturation: preload by running 65 535 compares (or force cmp_count), then run one more.
  - Expected: cmp_count remains 0xFFFF.

Source files
------------

// File: rtl/cmp_share_sched.sv
// ---------------------------------------------------------------------------
// cmp_share_sched
//
// Round-robin scheduler that time-shares one registered magnitude comparator
// among N_REQ requesters. A granted transaction always runs the fixed
// sequence IDLE -> CAPTURE -> EVAL -> DONE -> IDLE, so one compare completes
// every four cycles and no requester can be starved.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester request level, held until ack
//   a_flat     operand A of requester i at bits [i*W +: W]
//   b_flat     operand B of requester i at bits [i*W +: W]
//   ack        one-hot, one-cycle pulse in DONE to the served requester
//   res_valid  result qualifier, high only in DONE
//   res_id     index of the served requester
//   res_gt     A > B (unsigned)
//   res_eq     A == B
//   res_lt     A < B
//   busy       high whenever the FSM is not in IDLE
//   cmp_count  number of completed compares, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module cmp_share_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_flat,
    input  logic [N_REQ*W-1:0] b_flat,
    output logic [N_REQ-1:0]   ack,
    output logic               res_valid,
    output logic [2:0]         res_id,
    output logic               res_gt,
    output logic               res_eq,
    output logic               res_lt,
    output logic               busy,
    output logic [15:0]        cmp_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;

    logic [2:0]       winner;
    logic             found;
    logic [7:0]       req_ext;
    int               scan;

    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [N_REQ-1:0] res_onehot;

    // Round-robin arbiter: scan the requests starting at ptr and wrapping
    // modulo N_REQ, taking the first one that is set. The request vector is
    // zero-extended to eight entries so a 3-bit index always fits it exactly.
    always_comb begin
        winner  = ptr;
        found   = 1'b0;
        scan    = 0;
        req_ext = 8'(req);
        for (int k = 0; k < N_REQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            if (!found && req_ext[3'(scan)]) begin
                found  = 1'b1;
                winner = 3'(scan);
            end
        end
    end

    // Operand multiplexer and ack decode for the requester held in res_id.
    // Constant slice bases keep every select a fixed-width part select.
    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        res_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (res_id == 3'(i)) begin
                sel_a         = a_flat[i*W +: W];
                sel_b         = b_flat[i*W +: W];
                res_onehot[i] = 1'b1;
            end
        end
    end

    // Main FSM. All outputs are registered here: ack and res_valid are set
    // on the EVAL->DONE edge and cleared on the DONE->IDLE edge, so they
    // depend only on state and res_id, never combinationally on req.
    // Once granted, a transaction runs to completion even if req drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            ack       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_gt    <= 1'b0;
            res_eq    <= 1'b0;
            res_lt    <= 1'b0;
            busy      <= 1'b0;
            cmp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack       <= '0;
                    res_valid <= 1'b0;
                    if (found) begin
                        res_id <= winner;
                        busy   <= 1'b1;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    op_a  <= sel_a;
                    op_b  <= sel_b;
                    state <= EVAL;
                end
                EVAL: begin
                    res_gt    <= (op_a > op_b);
                    res_eq    <= (op_a == op_b);
                    res_lt    <= (op_a < op_b);
                    ack       <= res_onehot;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    ack       <= '0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (res_id == 3'(N_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= res_id + 3'd1;
                    end
                    if (cmp_count != 16'hFFFF) begin
                        cmp_count <= cmp_count + 16'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
